scarv_cop_mem_arbiter: RTL and testbench
========================================

// Module: scarv_cop_mem_arbiter
// PURPOSE
//  Shares one data-memory port between the host CPU data port and the
//  coprocessor load/store unit (cop_mem_* bus). At most one transaction is
//  outstanding at a time. Grant changes only on transaction boundaries.
//  A lock input lets a coprocessor scatter/gather keep the port for
//  consecutive accesses, bounded by LOCK_MAX.
// PARAMETERS
//  RR_EN     1  1: round-robin on contention; 0: coprocessor always wins
//  LOCK_MAX  4  max consecutive locked coprocessor grants while CPU waits
// PORTS
//  g_clk      in   1   global clock
//  g_resetn   in   1   asynchronous active-low reset
//  cpu_cen/cop_cen        in   1   request valid, held until its completion cycle
//  cpu_wen/cop_wen        in   1   store when 1
//  cpu_addr/cop_addr      in   32  word-aligned address
//  cpu_wdata/cop_wdata    in   32  write data
//  cpu_ben/cop_ben        in   4   byte enables
//  cop_lock               in   1   coprocessor requests back-to-back ownership
//  cpu_rdata/cop_rdata    out  32  read data; 0 unless completing for that port
//  cpu_stall/cop_stall    out  1   0 only in that port's completion cycle
//  cpu_error/cop_error    out  1   bus error in that port's completion cycle
//  mem_cen/mem_wen        out  1   downstream request, write
//  mem_addr/mem_wdata     out  32  downstream address, write data
//  mem_ben                out  4   downstream byte enables
//  mem_rdata              in   32  downstream read data
//  mem_stall/mem_error    in   1   downstream stall, error
// BEHAVIOUR
//  Bus protocol (all ports):
//  - Request issued in cycle t with cen=1.
//  - Completes in first cycle >t with stall=0; rdata/error valid then.
//  - Request fields held while stalled.
//  - A new request may be presented in the completion cycle.
//  State, async reset to IDLE: owner of outstanding txn, one of IDLE/COP/CPU.
//  Other regs: last_grant (reset CPU), lock_cnt (reset 0).
//  free = (state==IDLE) || !mem_stall.
//  Completion cycle = state!=IDLE && !mem_stall:
//  - Owner gets stall=0, rdata=mem_rdata, error=mem_error.
//  - Non-owner gets stall=1, rdata=0, error=0.
//  - All other cycles: both stalls=1, rdatas=0, errors=0.
//  When free, grant is decided combinationally in the same cycle:
//  - Only one cen: that port.
//  - Both: COP if cop_lock && last_grant==COP && lock_cnt<LOCK_MAX.
//    Else, if RR_EN: the port != last_grant. Else: COP.
//  - Mux selects the grantee; mem_cen=1.
//  - Next state = grantee; last_grant <= grantee.
//  - No cen: mem_cen=0, next state IDLE.
//  When not free: mux holds on state owner; mem_cen = owner's cen (held).
//  lock_cnt, width clog2(LOCK_MAX+1):
//  - COP grant: cop_lock ? min(lock_cnt+1, LOCK_MAX) : 0.
//  - CPU grant: 0.
//  - Unchanged otherwise.
//  Lock never blocks a lone requester. A CPU waiting when lock_cnt hits
//  LOCK_MAX wins the next free cycle.
//  mem_* outputs are 0 when mem_cen=0.
//  Reset mid-transaction: outstanding response is dropped; both stalls=1
//  until new grant completes.
//  Latency: request granted in a free cycle reaches mem_cen same cycle
//  (zero added latency).
// TESTING
//  - Idle; cpu_cen at t, addr 0x100, mem_stall=0 -> mem_cen/addr=0x100
//    at t; cpu_stall=0 at t+1 with cpu_rdata=mem_rdata; cop_stall=1.
//  - Both cen at t, RR_EN=1, last=CPU -> COP granted t.
//    CPU granted t+1 in COP completion cycle; grants then alternate.
//  - Cop holds cop_lock, 4 accesses, CPU waiting, LOCK_MAX=4 -> COP wins 4.
//    CPU wins 5th boundary; lock_cnt returns to 0.
//  - COP owns, mem_stall=1 for 3 cycles, cpu_cen high -> mem_addr stays COP.
//    cpu_stall=1 throughout; CPU granted in COP completion cycle.
//  - mem_error=1 at CPU completion -> cpu_error=1, cpu_stall=0; cop_error=0.
//  - g_resetn low mid-stall -> mem_cen=0, both stalls=1, state IDLE
//    asynchronously. First post-reset tie goes to COP.

Source files
------------

// File: rtl/scarv_cop_mem_arbiter.sv
// Shares one data-memory port between the host CPU and the coprocessor LSU.
// At most one transaction is outstanding at a time. The grant is decided
// combinationally in any free cycle, so a granted request reaches the memory
// port with no added latency. A coprocessor lock can hold the port for up to
// LOCK_MAX back-to-back accesses while the CPU waits.
module scarv_cop_mem_arbiter #(
  parameter bit RR_EN    = 1'b1,
  parameter int LOCK_MAX = 4
) (
  input  logic        g_clk,
  input  logic        g_resetn,

  input  logic        cpu_cen,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_ben,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_error,

  input  logic        cop_cen,
  input  logic        cop_wen,
  input  logic [31:0] cop_addr,
  input  logic [31:0] cop_wdata,
  input  logic [3:0]  cop_ben,
  input  logic        cop_lock,
  output logic [31:0] cop_rdata,
  output logic        cop_stall,
  output logic        cop_error,

  output logic        mem_cen,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_ben,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall,
  input  logic        mem_error
);

  localparam int LW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COP = 2'd1, ST_CPU = 2'd2} state_t;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
  } req_t;

  state_t        state_q, state_d;
  logic          last_cop_q, last_cop_d;   // 1: most recent grant went to COP
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;

  logic free, done, gnt_cop, gnt_cpu, sel_cop, req_vld;
  req_t cpu_req, cop_req, mem_req;

  assign cpu_req = '{wen: cpu_wen, addr: cpu_addr, wdata: cpu_wdata, ben: cpu_ben};
  assign cop_req = '{wen: cop_wen, addr: cop_addr, wdata: cop_wdata, ben: cop_ben};

  // Grant decision, downstream mux and next-state computation.
  always_comb begin
    free       = (state_q == ST_IDLE) || !mem_stall;
    done       = (state_q != ST_IDLE) && !mem_stall;
    gnt_cop    = 1'b0;
    gnt_cpu    = 1'b0;
    state_d    = state_q;
    last_cop_d = last_cop_q;
    lock_cnt_d = lock_cnt_q;
    // Reset gating keeps the port quiet while reset is asserted even if
    // requesters still hold cen.
    if (free && g_resetn) begin
      if (cop_cen && !cpu_cen) begin
        gnt_cop = 1'b1;
      end else if (cpu_cen && !cop_cen) begin
        gnt_cpu = 1'b1;
      end else if (cop_cen && cpu_cen) begin
        if (cop_lock && last_cop_q && (lock_cnt_q < LOCK_MAX[LW-1:0])) gnt_cop = 1'b1;
        else if (RR_EN)                                                gnt_cop = !last_cop_q;
        else                                                           gnt_cop = 1'b1;
        gnt_cpu = !gnt_cop;
      end
    end
    if (free) begin
      state_d = gnt_cop ? ST_COP : (gnt_cpu ? ST_CPU : ST_IDLE);
    end
    if (gnt_cop) begin
      last_cop_d = 1'b1;
      if (!cop_lock)                           lock_cnt_d = '0;
      else if (lock_cnt_q != LOCK_MAX[LW-1:0]) lock_cnt_d = lock_cnt_q + LW'(1);
    end else if (gnt_cpu) begin
      last_cop_d = 1'b0;
      lock_cnt_d = '0;
    end
    // While stalled the mux stays on the owner, whose request is held.
    sel_cop = free ? gnt_cop : (state_q == ST_COP);
    req_vld = free ? (gnt_cop || gnt_cpu) : (sel_cop ? cop_cen : cpu_cen);
    mem_req = req_vld ? (sel_cop ? cop_req : cpu_req) : '0;
  end

  assign mem_cen   = req_vld;
  assign mem_wen   = mem_req.wen;
  assign mem_addr  = mem_req.addr;
  assign mem_wdata = mem_req.wdata;
  assign mem_ben   = mem_req.ben;

  // Response routing: only the owner sees the completion cycle.
  always_comb begin
    cop_stall = !(done && (state_q == ST_COP));
    cpu_stall = !(done && (state_q == ST_CPU));
    cop_rdata = cop_stall ? 32'h0 : mem_rdata;
    cpu_rdata = cpu_stall ? 32'h0 : mem_rdata;
    cop_error = !cop_stall && mem_error;
    cpu_error = !cpu_stall && mem_error;
  end

  // Ownership, last grant and lock counter state.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q    <= ST_IDLE;
      last_cop_q <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_cop_q <= last_cop_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: tb/tb_scarv_cop_mem_arbiter.sv
// Directed bench for scarv_cop_mem_arbiter. Stimulus pushes expected grants
// and expected completions into queues; a negedge monitor pops and compares.
module tb_scarv_cop_mem_arbiter;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        cpu_cen = 0, cpu_wen = 0, cop_cen = 0, cop_wen = 0, cop_lock = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cop_addr = 0, cop_wdata = 0;
  logic [3:0]  cpu_ben = 0, cop_ben = 0;
  logic [31:0] cpu_rdata, cop_rdata;
  logic        cpu_stall, cop_stall, cpu_error, cop_error;
  logic        mem_cen, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_ben;
  logic        mem_stall = 0, mem_error = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_mem_arbiter #(.RR_EN(1'b1), .LOCK_MAX(4)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ben(cpu_ben), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_error(cpu_error),
    .cop_cen(cop_cen), .cop_wen(cop_wen), .cop_addr(cop_addr), .cop_wdata(cop_wdata),
    .cop_ben(cop_ben), .cop_lock(cop_lock), .cop_rdata(cop_rdata), .cop_stall(cop_stall),
    .cop_error(cop_error),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ben(mem_ben), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_error(mem_error)
  );

  typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] ben; } gexp_t;
  typedef struct { logic cop; logic [31:0] rdata; logic err; } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t held;
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Downstream memory model: read data is derived from the issued address.
  logic        outst;
  logic [31:0] cur_addr;
  assign mem_rdata = cur_addr ^ 32'hA5A5_0000;

  always @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      outst    <= 1'b0;
      cur_addr <= 32'h0;
    end else if (!outst || !mem_stall) begin
      outst <= mem_cen;
      if (mem_cen) cur_addr <= mem_addr;
    end
  end

  // Monitor: checks issues, holds and completions against the queues.
  always @(negedge g_clk) begin
    if (g_resetn) begin
      if (cpu_stall) begin
        chk("cpu_stalled_rdata", cpu_rdata, 0);
        chk("cpu_stalled_err", 32'(cpu_error), 0);
      end
      if (cop_stall) begin
        chk("cop_stalled_rdata", cop_rdata, 0);
        chk("cop_stalled_err", 32'(cop_error), 0);
      end
      if (!cpu_stall || !cop_stall) begin
        chk("single_completion", 32'(cpu_stall ^ cop_stall), 1);
        if (rq.size() == 0) begin
          chk("unexpected_completion", 32'(cop_stall), 32'(cpu_stall));
        end else begin
          rexp_t r;
          r = rq.pop_front();
          if (r.cop) begin
            chk("cop_done", 32'(cop_stall), 0);
            chk("cop_rdata", cop_rdata, r.rdata);
            chk("cop_error", 32'(cop_error), 32'(r.err));
          end else begin
            chk("cpu_done", 32'(cpu_stall), 0);
            chk("cpu_rdata", cpu_rdata, r.rdata);
            chk("cpu_error", 32'(cpu_error), 32'(r.err));
          end
        end
      end
      if (!mem_cen) begin
        chk("mem_idle_zero", mem_addr | mem_wdata | {28'h0, mem_ben} | {31'h0, mem_wen}, 0);
      end
      if (!outst || !mem_stall) begin
        if (mem_cen) begin
          if (gq.size() == 0) begin
            chk("unexpected_grant", mem_addr, 32'hFFFF_FFFF);
          end else begin
            held = gq.pop_front();
            chk("grant_addr", mem_addr, held.addr);
            chk("grant_wen", 32'(mem_wen), 32'(held.wen));
            chk("grant_wdata", mem_wdata, held.wdata);
            chk("grant_ben", 32'(mem_ben), 32'(held.ben));
          end
        end
      end else begin
        chk("hold_cen", 32'(mem_cen), 1);
        chk("hold_addr", mem_addr, held.addr);
      end
    end
  end

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic pg(input logic [31:0] a, input logic w, input logic [31:0] d);
    gexp_t g;
    g.addr = a; g.wen = w; g.wdata = d; g.ben = 4'hF;
    gq.push_back(g);
  endtask

  task automatic pr(input logic c, input logic [31:0] a, input logic e);
    rexp_t r;
    r.cop = c; r.rdata = a ^ 32'hA5A5_0000; r.err = e;
    rq.push_back(r);
  endtask

  initial begin
    cpu_ben = 4'hF;
    cop_ben = 4'hF;
    #1;
    chk("rst_cpu_stall", 32'(cpu_stall), 1);
    chk("rst_cop_stall", 32'(cop_stall), 1);
    chk("rst_mem_cen", 32'(mem_cen), 0);
    chk("rst_rdata", cpu_rdata | cop_rdata, 0);
    repeat (2) @(posedge g_clk);
    #1 g_resetn = 1'b1;

    // Lone CPU read, zero-latency issue, completion next cycle.
    cpu_cen = 1; cpu_addr = 32'h100; pg(32'h100, 0, 0);
    cyc(); cpu_cen = 0; pr(0, 32'h100, 0);
    cyc();

    // Contention with last grant CPU: COP first, then alternating.
    cop_cen = 1; cop_addr = 32'h200;
    cpu_cen = 1; cpu_addr = 32'h300; cpu_wen = 1; cpu_wdata = 32'h11;
    pg(32'h200, 0, 0);
    cyc(); cop_addr = 32'h204; pr(1, 32'h200, 0); pg(32'h300, 1, 32'h11);
    cyc(); cpu_addr = 32'h304; cpu_wen = 0; cpu_wdata = 0; pr(0, 32'h300, 0); pg(32'h204, 0, 0);
    cyc(); cop_cen = 0; pr(1, 32'h204, 0); pg(32'h304, 0, 0);
    cyc(); cpu_cen = 0; pr(0, 32'h304, 0);
    cyc();

    // Locked COP takes 4 grants, CPU wins the 5th boundary.
    cop_cen = 1; cop_lock = 1; cop_addr = 32'h400;
    cpu_cen = 1; cpu_addr = 32'h500;
    pg(32'h400, 0, 0);
    for (int i = 1; i < 4; i++) begin
      cyc(); cop_addr = 32'h400 + 32'(4 * i);
      pr(1, 32'h400 + 32'(4 * (i - 1)), 0); pg(32'h400 + 32'(4 * i), 0, 0);
    end
    cyc(); cop_addr = 32'h410; pr(1, 32'h40C, 0); pg(32'h500, 0, 0);
    cyc(); cpu_cen = 0; pr(0, 32'h500, 0); pg(32'h410, 0, 0);
    cyc(); cop_cen = 0; cop_lock = 0; pr(1, 32'h410, 0);
    cyc();

    // COP owns through 3 stall cycles with CPU waiting.
    cop_cen = 1; cop_addr = 32'h600; pg(32'h600, 0, 0);
    cyc(); mem_stall = 1; cpu_cen = 1; cpu_addr = 32'h700;
    cyc();
    cyc();
    cyc(); mem_stall = 0; cop_cen = 0; pr(1, 32'h600, 0); pg(32'h700, 0, 0);
    cyc(); cpu_cen = 0; pr(0, 32'h700, 0);
    cyc();

    // Bus error on a CPU completion only reaches the CPU.
    cpu_cen = 1; cpu_addr = 32'h800; pg(32'h800, 0, 0);
    cyc(); cpu_cen = 0; mem_error = 1; cop_cen = 1; cop_addr = 32'h804;
    pr(0, 32'h800, 1); pg(32'h804, 0, 0);
    cyc(); mem_error = 0; cop_cen = 0; pr(1, 32'h804, 0);
    cyc();

    // Reset mid-stall drops the outstanding response.
    cop_cen = 1; cop_addr = 32'h900; pg(32'h900, 0, 0);
    cyc(); mem_stall = 1;
    #2 g_resetn = 1'b0;
    #1;
    chk("arst_mem_cen", 32'(mem_cen), 0);
    chk("arst_cpu_stall", 32'(cpu_stall), 1);
    chk("arst_cop_stall", 32'(cop_stall), 1);
    cyc(); g_resetn = 1'b1; mem_stall = 0;
    cop_addr = 32'hA00; cpu_cen = 1; cpu_addr = 32'hB00; pg(32'hA00, 0, 0);
    cyc(); cop_cen = 0; pr(1, 32'hA00, 0); pg(32'hB00, 0, 0);
    cyc(); cpu_cen = 0; pr(0, 32'hB00, 0);
    cyc();
    cyc();

    chk("grant_queue_drained", 32'(gq.size()), 0);
    chk("resp_queue_drained", 32'(rq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
